// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue front-end and its consumers.
// Command encodings, FSM state encoding and the default datapath width.
package alu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W     = 4;

    localparam logic [2:0] CMD_ADD  = 3'b000;
    localparam logic [2:0] CMD_SUB  = 3'b001;
    localparam logic [2:0] CMD_XOR  = 3'b010;
    localparam logic [2:0] CMD_SLT  = 3'b011;
    localparam logic [2:0] CMD_AND  = 3'b100;
    localparam logic [2:0] CMD_NAND = 3'b101;
    localparam logic [2:0] CMD_NOR  = 3'b110;
    localparam logic [2:0] CMD_OR   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_result_norm.sv
// Combinational post-processing of raw ALU outputs: SLT bit moved
// from the MSB to bit 0, and the zero flag recomputed from the result.
module alu_result_norm
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2:0]       command,
    input  logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] norm_result,
    output logic             zero
);

    always_comb begin
        norm_result = result;
        if (command == CMD_SLT) begin
            norm_result = {{(WIDTH-1){1'b0}}, result[WIDTH-1]};
        end
    end

    assign zero = ~|norm_result;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/settle/response sequencer in front of the gate-level ALU.
// Optional sticky overflow/carry flags via ALU_STICKY_FLAGS_EN.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEF,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_cmd,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_command,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carryout,
    output logic             rsp_overflow,
    output logic             rsp_zero,
`ifdef ALU_STICKY_FLAGS_EN
    input  logic             flag_clear,
    output logic             sticky_overflow,
    output logic             sticky_carry,
`endif
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             capture;
    logic [WIDTH-1:0] norm_result;
    logic             norm_zero;
    logic             unused_zero;

    // Zero is recomputed after SLT normalization; the ALU's own flag is ignored.
    assign unused_zero = alu_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_LOAD;
        end else if (state == ST_SETTLE && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_command <= '0;
        end else if (accept) begin
            alu_a       <= req_a;
            alu_b       <= req_b;
            alu_command <= req_cmd;
        end
    end

    alu_result_norm #(
        .WIDTH(WIDTH)
    ) u_norm (
        .command    (alu_command),
        .result     (alu_result),
        .norm_result(norm_result),
        .zero       (norm_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_result   <= '0;
            rsp_carryout <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
        end else if (capture) begin
            rsp_result   <= norm_result;
            rsp_carryout <= alu_carryout;
            rsp_overflow <= alu_overflow;
            rsp_zero     <= norm_zero;
        end
    end

`ifdef ALU_STICKY_FLAGS_EN
    // A flagged capture beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_overflow <= 1'b0;
            sticky_carry    <= 1'b0;
        end else begin
            if (capture && alu_overflow) begin
                sticky_overflow <= 1'b1;
            end else if (flag_clear) begin
                sticky_overflow <= 1'b0;
            end
            if (capture && alu_carryout) begin
                sticky_carry <= 1'b1;
            end else if (flag_clear) begin
                sticky_carry <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl with an ideal ALU
// and an arithmetic reference model of the expected responses.
module tb_alu_issue_ctrl;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [2:0]   req_cmd;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_command;
    logic [W-1:0] alu_result;
    logic         alu_carryout;
    logic         alu_zero;
    logic         alu_overflow;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_carryout;
    logic         rsp_overflow;
    logic         rsp_zero;
    logic         busy;
`ifdef ALU_STICKY_FLAGS_EN
    logic         flag_clear;
    logic         sticky_overflow;
    logic         sticky_carry;
`endif

    int checks   = 0;
    int failures = 0;
    bit exp_sov  = 1'b0;
    bit exp_sc   = 1'b0;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        v;
    } exp_t;

    always #5 clk = ~clk;

    alu_issue_ctrl #(
        .WIDTH(W),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_cmd        (req_cmd),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_command    (alu_command),
        .alu_result     (alu_result),
        .alu_carryout   (alu_carryout),
        .alu_zero       (alu_zero),
        .alu_overflow   (alu_overflow),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_result     (rsp_result),
        .rsp_carryout   (rsp_carryout),
        .rsp_overflow   (rsp_overflow),
        .rsp_zero       (rsp_zero),
`ifdef ALU_STICKY_FLAGS_EN
        .flag_clear     (flag_clear),
        .sticky_overflow(sticky_overflow),
        .sticky_carry   (sticky_carry),
`endif
        .busy           (busy)
    );

    // Ideal ALU: SLT bit on the MSB with junk below, zero flag deliberately wrong.
    always_comb begin
        logic [32:0] s;
        logic        ov;
        s            = '0;
        ov           = 1'b0;
        alu_result   = '0;
        alu_carryout = 1'b0;
        alu_overflow = 1'b0;
        case (alu_command)
            3'b000: begin
                s            = {1'b0, alu_a} + {1'b0, alu_b};
                ov           = ~(alu_a[31] ^ alu_b[31]) & (alu_a[31] ^ s[31]);
                alu_result   = s[31:0];
                alu_carryout = s[32];
                alu_overflow = ov;
            end
            3'b001, 3'b011: begin
                s            = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                ov           = (alu_a[31] ^ alu_b[31]) & (alu_a[31] ^ s[31]);
                alu_carryout = s[32];
                alu_overflow = ov;
                if (alu_command == 3'b001) alu_result = s[31:0];
                else alu_result = {s[31] ^ ov, alu_a[30:0] ^ alu_b[30:0]};
            end
            default: begin
                case (alu_command)
                    3'b010:  alu_result = alu_a ^ alu_b;
                    3'b100:  alu_result = alu_a & alu_b;
                    3'b101:  alu_result = ~(alu_a & alu_b);
                    3'b110:  alu_result = ~(alu_a | alu_b);
                    default: alu_result = alu_a | alu_b;
                endcase
                alu_carryout = alu_a[0] ^ alu_b[0];
                alu_overflow = alu_a[1] & alu_b[1];
            end
        endcase
        alu_zero = |alu_result;
    end

    function automatic exp_t ref_op(logic [31:0] a, logic [31:0] b, logic [2:0] cmd);
        exp_t   e;
        longint t;
        e = '0;
        if (cmd == 3'b000) begin
            e.r = a + b;
            e.c = (33'(a) + 33'(b)) > 33'h0FFFFFFFF;
            t   = longint'($signed(a)) + longint'($signed(b));
            e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        end else if (cmd == 3'b001 || cmd == 3'b011) begin
            e.r = (cmd == 3'b001) ? a - b : (($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
            e.c = (a >= b);
            t   = longint'($signed(a)) - longint'($signed(b));
            e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        end else begin
            case (cmd)
                3'b010:  e.r = a ^ b;
                3'b100:  e.r = a & b;
                3'b101:  e.r = ~(a & b);
                3'b110:  e.r = ~(a | b);
                default: e.r = a | b;
            endcase
            e.c = a[0] ^ b[0];
            e.v = a[1] & b[1];
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] cmd, input int hold, input bit clr_cap);
        exp_t e;
        int   n;
        e = ref_op(a, b, cmd);
        @(negedge clk);
        req_a     = a;
        req_b     = b;
        req_cmd   = cmd;
        req_valid = 1'b1;
        rsp_ready = 1'($urandom);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        req_cmd   = 3'($urandom);
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
        check("alu_cmd", 32'(alu_command), 32'(cmd));
        n = 0;
        while (!rsp_valid && n < 64) begin
`ifdef ALU_STICKY_FLAGS_EN
            flag_clear = clr_cap && (n == S - 1);
`endif
            @(negedge clk);
            n++;
        end
`ifdef ALU_STICKY_FLAGS_EN
        flag_clear = 1'b0;
        exp_sov = e.v ? 1'b1 : (clr_cap ? 1'b0 : exp_sov);
        exp_sc  = e.c ? 1'b1 : (clr_cap ? 1'b0 : exp_sc);
`endif
        check("latency", 32'(n), 32'(S));
        check("result", rsp_result, e.r);
        check("carry", 32'(rsp_carryout), 32'(e.c));
        check("overflow", 32'(rsp_overflow), 32'(e.v));
        check("zero", 32'(rsp_zero), 32'(e.r == 32'd0));
        check("busy_resp", 32'(busy), 32'd1);
`ifdef ALU_STICKY_FLAGS_EN
        check("sticky_ovf", 32'(sticky_overflow), 32'(exp_sov));
        check("sticky_carry", 32'(sticky_carry), 32'(exp_sc));
`endif
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_a     = $urandom;
            req_b     = $urandom;
            @(negedge clk);
            check("bp_result", rsp_result, e.r);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_alu_a", alu_a, a);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        check("ready_after", 32'(req_ready), 32'd1);
        check("no_accept_hs", alu_a, a);
    endtask

    initial begin
        logic [31:0] pick [8];
        int          silent;
        pick = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF,
                 32'h80000000, 32'h5, 32'hAAAA5555, 32'h12345678};
        reset     = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_cmd   = '0;
        rsp_ready = 1'b0;
`ifdef ALU_STICKY_FLAGS_EN
        flag_clear = 1'b0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_result", rsp_result, 32'd0);
        check("rst_zero", 32'(rsp_zero), 32'd0);

        run_op(32'h7FFFFFFF, 32'h00000001, 3'b000, 0, 1'b0);
        run_op(32'd5, 32'd5, 3'b001, 0, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000001, 3'b011, 0, 1'b0);
        run_op(32'h00000001, 32'hFFFFFFFF, 3'b011, 0, 1'b0);
        run_op(32'h12345678, 32'h0F0F0F0F, 3'b111, 6, 1'b0);

        // Abort an operation mid-settle with the request bus changing.
        @(negedge clk);
        req_a     = 32'h1;
        req_b     = 32'h2;
        req_cmd   = 3'b000;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = 32'hDEADBEEF;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 32'(rsp_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_alu_a", alu_a, 32'd0);
        check("arst_alu_b", alu_b, 32'd0);
        exp_sov = 1'b0;
        exp_sc  = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        silent = 0;
        repeat (S + 3) begin
            @(negedge clk);
            if (rsp_valid) silent++;
        end
        check("no_rsp_after_rst", 32'(silent), 32'd0);
        run_op(32'hF0F0F0F0, 32'h0FF00FF0, 3'b100, 1, 1'b0);

`ifdef ALU_STICKY_FLAGS_EN
        run_op(32'h7FFFFFFF, 32'h1, 3'b000, 0, 1'b0);
        run_op(32'h1, 32'h1, 3'b000, 0, 1'b0);
        run_op(32'h7FFFFFFF, 32'h1, 3'b000, 0, 1'b1);
        @(negedge clk);
        flag_clear = 1'b1;
        @(negedge clk);
        flag_clear = 1'b0;
        exp_sov = 1'b0;
        exp_sc  = 1'b0;
        check("clr_ovf", 32'(sticky_overflow), 32'(exp_sov));
        check("clr_carry", 32'(sticky_carry), 32'(exp_sc));
`endif

        for (int k = 0; k < 40; k++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 7)] : $urandom;
            rb = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 7)] : $urandom;
            run_op(ra, rb, 3'($urandom), $urandom_range(0, 3), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencing front-end for the 32-bit gate-level ALU.
- Accepts operation requests over a valid/ready handshake and drives the ALU's A/B/command inputs from registers.
- Holds those inputs stable for a programmable settle window, because the ALU's gate delays make its outputs valid only after propagation.
- Samples result and flags, normalizes SLT, and returns a registered response over a second valid/ready handshake.

Parameters:
- WIDTH, 32: operand/result width; must match the ALU.
- SETTLE_CYCLES, 4: clock cycles the ALU inputs are held before outputs are sampled; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_cmd  in  3  ALU command: 000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR.
- alu_a  out  WIDTH  registered operand to ALU A.
- alu_b  out  WIDTH  registered operand to ALU B.
- alu_command  out  3  registered command to ALU.
- alu_result  in  WIDTH  ALU result.
- alu_carryout  in  1  ALU carry out.
- alu_zero  in  1  ALU zero flag (unused; zero is recomputed).
- alu_overflow  in  1  ALU overflow.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  WIDTH  normalized result.
- rsp_carryout  out  1  captured carry out.
- rsp_overflow  out  1  captured overflow.
- rsp_zero  out  1  ~|rsp_result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, active-high): state=IDLE; settle counter=0; alu_a, alu_b, alu_command = 0; all rsp_* = 0; busy=0. Reset mid-operation abandons the operation with no response; rsp_valid drops immediately.
- States: IDLE, SETTLE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: register req_a/b/cmd onto alu_a/b/command, load counter=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - req_ready=0; alu_* held constant.
  - If counter!=0: decrement.
  - If counter==0: capture ALU outputs into rsp_* and go to RESP.
  - Capture therefore occurs at edge N+SETTLE_CYCLES, where N is the accept edge.
- RESP:
  - rsp_valid=1; req_ready=0; rsp_* held stable until rsp_valid&rsp_ready.
  - On that handshake: go to IDLE, rsp_valid deasserts next cycle.
  - No request can be accepted in the same cycle; throughput is one operation per SETTLE_CYCLES+2 cycles minimum.
- SLT normalization: the ALU places the SLT bit on result[WIDTH-1]. When alu_command==011, rsp_result = {(WIDTH-1)'b0, alu_result[WIDTH-1]}. All other commands pass alu_result through unchanged.
- rsp_zero is derived from the normalized rsp_result, not from alu_zero.
- Flags: rsp_carryout and rsp_overflow are captured for every command. They are meaningful only for ADD/SUB/SLT; for other commands they are passed through, not masked.
- alu_* keep their last values through RESP and IDLE; they change only on accept.
- req_* are sampled only on the accept edge; changes while busy are ignored.
- rsp_ready asserted while rsp_valid=0 has no effect.

Optional Feature:
- Macro: ALU_STICKY_FLAGS_EN.
- Defined:
  - Adds input flag_clear (1) and outputs sticky_overflow (1) and sticky_carry (1).
  - Each sticky bit is set on a capture whose flag is 1.
  - Each is cleared synchronously by flag_clear.
  - If a capture and flag_clear occur in the same cycle, the capture wins (bit set).
  - Both reset to 0.
- Undefined: the three ports and their logic do not exist.

Decomposition:
- Shared package alu_pkg:
  - 3-bit command constants CMD_ADD..CMD_OR.
  - State encoding constants ST_IDLE, ST_SETTLE, ST_RESP.
  - Default WIDTH.
- One natural sub-module, alu_result_norm: combinational SLT normalization plus zero recompute. It is shared with any future ALU consumers.

Test Plan:
- ADD, A=0x7FFFFFFF, B=0x00000001, SETTLE_CYCLES=4 -> rsp_valid rises exactly 4 edges after accept; rsp_result=0x80000000, rsp_overflow=1, rsp_carryout=0, rsp_zero=0.
- SUB, A=5, B=5 -> rsp_result=0x00000000, rsp_zero=1, rsp_carryout=1.
- SLT, A=0xFFFFFFFF, B=0x00000001 -> rsp_result=0x00000001, rsp_zero=0. SLT, A=1, B=0xFFFFFFFF -> rsp_result=0, rsp_zero=1.
- Backpressure: rsp_ready held low for 6 cycles after rsp_valid -> rsp_* stable, req_ready=0, busy=1; a new request with req_valid=1 is not accepted until the cycle after the response handshake.
- Reset asserted mid-SETTLE, with operands changed on req_* while busy -> async clear to IDLE, alu_a=alu_b=0, rsp_valid=0, no response emitted; the next request returns the correct AND result (0xF0F0F0F0 & 0x0FF00FF0 = 0x00F000F0).
- ALU_STICKY_FLAGS_EN: ADD overflow, then ADD 1+1 -> sticky_overflow stays 1; flag_clear pulsed on a capture cycle with overflow -> remains 1; flag_clear alone -> 0.
